// File: rtl/pow_fsmd_param_if.sv
// Start/busy/done handshake bundle for the square-and-multiply power unit.
// The requester drives operands; the engine returns status and the held result.
interface pow_fsmd_param_if #(
    parameter int WIDTH = 16,
    parameter int EXP_W = 8
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [EXP_W-1:0] exp;
    logic             sat_mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output start, base, exp, sat_mode,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, base, exp, sat_mode,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/pow_fsmd_param.sv
// Right-to-left square-and-multiply exponentiation with exact overflow detection
// and selectable wrap/saturate result; one exponent bit per CHECK + ODD/EVEN pair.
module pow_fsmd_param #(
    parameter int WIDTH = 16,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    pow_fsmd_param_if.slave  bus_if
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_ODD   = 3'd3,
        S_EVEN  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             a_ovf_q, a_ovf_d;
    logic [EXP_W-1:0] n_q, n_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] prod_r;
    logic [2*WIDTH-1:0] prod_a;

    // Full double-width products so the upper half reveals true overflow.
    assign prod_r = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, a_q};
    assign prod_a = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, a_q};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        a_ovf_d    = a_ovf_q;
        n_d        = n_q;
        r_d        = r_q;
        ovf_d      = ovf_q;
        mode_d     = mode_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    a_d     = bus_if.base;
                    n_d     = bus_if.exp;
                    mode_d  = bus_if.sat_mode;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                r_d     = WIDTH'(1);
                ovf_d   = 1'b0;
                a_ovf_d = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (n_q == '0)
                    state_d = S_DONE;
                else if (n_q[0])
                    state_d = S_ODD;
                else
                    state_d = S_EVEN;
            end
            S_ODD: begin
                // A wrapped multiplicand poisons r only once it is actually used.
                r_d     = prod_r[WIDTH-1:0];
                ovf_d   = ovf_q | a_ovf_q | (prod_r[2*WIDTH-1:WIDTH] != '0);
                a_d     = prod_a[WIDTH-1:0];
                a_ovf_d = a_ovf_q | (prod_a[2*WIDTH-1:WIDTH] != '0);
                n_d     = n_q >> 1;
                state_d = S_CHECK;
            end
            S_EVEN: begin
                a_d     = prod_a[WIDTH-1:0];
                a_ovf_d = a_ovf_q | (prod_a[2*WIDTH-1:WIDTH] != '0);
                n_d     = n_q >> 1;
                state_d = S_CHECK;
            end
            S_DONE: begin
                result_d   = (ovf_q && mode_q) ? {WIDTH{1'b1}} : r_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            a_ovf_q    <= 1'b0;
            n_q        <= '0;
            r_q        <= '0;
            ovf_q      <= 1'b0;
            mode_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            a_ovf_q    <= a_ovf_d;
            n_q        <= n_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
            mode_q     <= mode_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bus_if.busy     = (state_q != S_IDLE);
    assign bus_if.done     = done_q;
    assign bus_if.result   = result_q;
    assign bus_if.overflow = overflow_q;

endmodule
